// File: rtl/render_pkg.sv
// Shared types for the wireframe triangle scheduler: coordinate width, edge ids, FSM states, vertex.
package render_pkg;

    localparam int COORD_W = 21;

    localparam logic [1:0] EDGE_AB = 2'd0;
    localparam logic [1:0] EDGE_BC = 2'd1;
    localparam logic [1:0] EDGE_CA = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EDGE0 = 2'd1,
        EDGE1 = 2'd2,
        EDGE2 = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } vertex_t;

endpackage

// File: rtl/edge_tester.sv
// Pipelined point-on-segment test (cross product near zero and inside the segment bbox).
// Latency 3 cycles, one test per cycle, no backpressure; tags travel with the data.
module edge_tester
    import render_pkg::*;
#(
    parameter int SHIFT = 6,
    parameter int TH    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       issue_i,
    input  logic [1:0] edge_i,
    input  logic       last_i,
    input  vertex_t    s_i,
    input  vertex_t    t_i,
    input  vertex_t    p_i,
    output logic       vld_o,
    output logic [1:0] edge_o,
    output logic       last_o,
    output logic       hit_o
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * DW + 1;
    localparam logic signed [PW-1:0] TH_P = PW'(TH);
    localparam logic signed [PW-1:0] TH_N = -TH_P;

    function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] v);
        return {{(PW - DW){v[DW-1]}}, v};
    endfunction

    logic signed [COORD_W-1:0] sx, sy, tx, ty, px, py;
    logic signed [DW-1:0]      dtx_d, dty_d, dpx_d, dpy_d;
    logic                      box_d;

    always_comb begin
        sx    = s_i.x;
        sy    = s_i.y;
        tx    = t_i.x;
        ty    = t_i.y;
        px    = p_i.x;
        py    = p_i.y;
        dtx_d = {tx[COORD_W-1], tx} - {sx[COORD_W-1], sx};
        dty_d = {ty[COORD_W-1], ty} - {sy[COORD_W-1], sy};
        dpx_d = {px[COORD_W-1], px} - {sx[COORD_W-1], sx};
        dpy_d = {py[COORD_W-1], py} - {sy[COORD_W-1], sy};
        box_d = ((sx <= tx) ? (px >= sx && px <= tx) : (px >= tx && px <= sx)) &&
                ((sy <= ty) ? (py >= sy && py <= ty) : (py >= ty && py <= sy));
    end

    logic                 s1_vld_q, s1_last_q, s1_box_q;
    logic [1:0]           s1_edge_q;
    logic signed [DW-1:0] dtx_q, dty_q, dpx_q, dpy_q;
    logic                 s2_vld_q, s2_last_q, s2_box_q;
    logic [1:0]           s2_edge_q;
    logic signed [PW-1:0] cross_q;
    logic signed [PW-1:0] cross_d, shf;
    logic                 s3_vld_q, s3_last_q, s3_hit_q;
    logic [1:0]           s3_edge_q;

    always_comb begin
        cross_d = sext(dtx_q) * sext(dpy_q) - sext(dpx_q) * sext(dty_q);
        shf     = cross_q >>> SHIFT;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_box_q  <= 1'b0;
            s1_edge_q <= '0;
            dtx_q     <= '0;
            dty_q     <= '0;
            dpx_q     <= '0;
            dpy_q     <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_box_q  <= 1'b0;
            s2_edge_q <= '0;
            cross_q   <= '0;
            s3_vld_q  <= 1'b0;
            s3_last_q <= 1'b0;
            s3_hit_q  <= 1'b0;
            s3_edge_q <= '0;
        end else begin
            s1_vld_q  <= issue_i;
            s1_last_q <= last_i;
            s1_box_q  <= box_d;
            s1_edge_q <= edge_i;
            dtx_q     <= dtx_d;
            dty_q     <= dty_d;
            dpx_q     <= dpx_d;
            dpy_q     <= dpy_d;

            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            s2_box_q  <= s1_box_q;
            s2_edge_q <= s1_edge_q;
            cross_q   <= cross_d;

            s3_vld_q  <= s2_vld_q;
            s3_last_q <= s2_last_q;
            s3_edge_q <= s2_edge_q;
            s3_hit_q  <= (shf > TH_N) && (shf < TH_P) && s2_box_q;
        end
    end

    assign vld_o  = s3_vld_q;
    assign edge_o = s3_edge_q;
    assign last_o = s3_last_q;
    assign hit_o  = s3_hit_q;

endmodule

// File: rtl/wire_tri_scheduler.sv
// Wireframe edge scheduler: shadow/active triangle, 3 edges per pixel through one shared tester.
// Accept-to-result 7 cycles, 1 pixel per 3 cycles; pix_ready held low while a swap is armed.
module wire_tri_scheduler
    import render_pkg::*;
#(
    parameter int SHIFT = 6,
    parameter int TH    = 2
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      vtx_wr_en,
    input  logic [1:0]                vtx_wr_sel,
    input  logic signed [COORD_W-1:0] vtx_wr_x,
    input  logic signed [COORD_W-1:0] vtx_wr_y,
    input  logic                      tri_commit,
    output logic                      cfg_busy,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic signed [COORD_W-1:0] pix_x,
    input  logic signed [COORD_W-1:0] pix_y,
    output logic                      out_valid,
    output logic                      out_hit,
    output logic [2:0]                out_mask,
    output logic                      tri_valid
);

    vertex_t    shadow_q [3];
    vertex_t    active_q [3];
    logic       pending_q, armed_q, tri_valid_q;
    state_e     state_q;
    vertex_t    pix_q;
    logic       iss_vld_q, iss_last_q;
    logic [1:0] iss_edge_q;
    vertex_t    iss_s_q, iss_t_q, iss_p_q;
    logic       accept, swap;

    assign pix_ready = ((state_q == IDLE) || (state_q == EDGE2)) && !armed_q;
    assign accept    = pix_valid && pix_ready;
    assign swap      = (state_q == IDLE) && armed_q;
    assign cfg_busy  = pending_q;
    assign tri_valid = tri_valid_q;

    // Swap only happens in IDLE, so every edge of one pixel sees the same active triangle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            pending_q   <= 1'b0;
            armed_q     <= 1'b0;
            tri_valid_q <= 1'b0;
        end else begin
            if (vtx_wr_en && !pending_q) begin
                case (vtx_wr_sel)
                    2'd0:    shadow_q[0] <= '{x: vtx_wr_x, y: vtx_wr_y};
                    2'd1:    shadow_q[1] <= '{x: vtx_wr_x, y: vtx_wr_y};
                    2'd2:    shadow_q[2] <= '{x: vtx_wr_x, y: vtx_wr_y};
                    default: ;
                endcase
            end
            if (swap) begin
                active_q    <= shadow_q;
                pending_q   <= 1'b0;
                armed_q     <= 1'b0;
                tri_valid_q <= 1'b1;
            end else begin
                if (tri_commit && !pending_q) pending_q <= 1'b1;
                if (frame_start && pending_q) armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            iss_vld_q  <= 1'b0;
            iss_last_q <= 1'b0;
            iss_edge_q <= EDGE_AB;
            iss_s_q    <= '0;
            iss_t_q    <= '0;
            iss_p_q    <= '0;
        end else begin
            case (state_q)
                IDLE, EDGE2: begin
                    if (accept) begin
                        state_q <= EDGE0;
                        pix_q   <= '{x: pix_x, y: pix_y};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EDGE0:   state_q <= EDGE1;
                default: state_q <= EDGE2;
            endcase

            iss_vld_q  <= (state_q != IDLE);
            iss_last_q <= (state_q == EDGE2);
            iss_p_q    <= pix_q;
            case (state_q)
                EDGE0: begin
                    iss_edge_q <= EDGE_AB;
                    iss_s_q    <= active_q[0];
                    iss_t_q    <= active_q[1];
                end
                EDGE1: begin
                    iss_edge_q <= EDGE_BC;
                    iss_s_q    <= active_q[1];
                    iss_t_q    <= active_q[2];
                end
                EDGE2: begin
                    iss_edge_q <= EDGE_CA;
                    iss_s_q    <= active_q[2];
                    iss_t_q    <= active_q[0];
                end
                default: ;
            endcase
        end
    end

    logic       res_vld, res_last, res_hit;
    logic [1:0] res_edge;

    edge_tester #(
        .SHIFT(SHIFT),
        .TH   (TH)
    ) u_edge_tester (
        .clk_i  (CLK),
        .rst_i  (rst),
        .issue_i(iss_vld_q),
        .edge_i (iss_edge_q),
        .last_i (iss_last_q),
        .s_i    (iss_s_q),
        .t_i    (iss_t_q),
        .p_i    (iss_p_q),
        .vld_o  (res_vld),
        .edge_o (res_edge),
        .last_o (res_last),
        .hit_o  (res_hit)
    );

    logic [2:0] acc_q, mask_d, final_d;
    logic       out_valid_q, out_hit_q;
    logic [2:0] out_mask_q;

    always_comb begin
        mask_d  = acc_q | (res_hit ? (3'b001 << res_edge) : 3'b000);
        final_d = tri_valid_q ? mask_d : 3'b000;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_mask_q  <= '0;
        end else begin
            out_valid_q <= res_vld && res_last;
            if (res_vld) begin
                if (res_last) begin
                    out_mask_q <= final_d;
                    out_hit_q  <= |final_d;
                    acc_q      <= '0;
                end else begin
                    acc_q <= mask_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_mask  = out_mask_q;

endmodule

// File: tb/tb_wire_tri_scheduler.sv
// Directed bench for wire_tri_scheduler: hand-computed masks, 7-cycle latency, swap and reset behaviour.
module tb_wire_tri_scheduler;
    import render_pkg::*;

    logic                      CLK = 1'b0;
    logic                      rst = 1'b1;
    logic                      vtx_wr_en = 1'b0;
    logic [1:0]                vtx_wr_sel = '0;
    logic signed [COORD_W-1:0] vtx_wr_x = '0;
    logic signed [COORD_W-1:0] vtx_wr_y = '0;
    logic                      tri_commit = 1'b0;
    logic                      cfg_busy;
    logic                      frame_start = 1'b0;
    logic                      pix_valid = 1'b0;
    logic                      pix_ready;
    logic signed [COORD_W-1:0] pix_x = '0;
    logic signed [COORD_W-1:0] pix_y = '0;
    logic                      out_valid, out_hit;
    logic [2:0]                out_mask;
    logic                      tri_valid;

    wire_tri_scheduler dut (
        .CLK(CLK), .rst(rst),
        .vtx_wr_en(vtx_wr_en), .vtx_wr_sel(vtx_wr_sel), .vtx_wr_x(vtx_wr_x), .vtx_wr_y(vtx_wr_y),
        .tri_commit(tri_commit), .cfg_busy(cfg_busy), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .out_valid(out_valid), .out_hit(out_hit), .out_mask(out_mask), .tri_valid(tri_valid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Accept edge and result edge are both expressed as posedge indices.
    int         acc_edge [$];
    int         res_edge [$];
    logic [2:0] res_mask [$];
    logic       res_hit  [$];

    always @(negedge CLK) begin
        if (!rst && pix_valid && pix_ready) acc_edge.push_back(cyc + 1);
        if (out_valid) begin
            res_edge.push_back(cyc);
            res_mask.push_back(out_mask);
            res_hit.push_back(out_hit);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        acc_edge.delete();
        res_edge.delete();
        res_mask.delete();
        res_hit.delete();
    endtask

    task automatic wr_vtx(input logic [1:0] sel, input int x, input int y);
        vtx_wr_en  = 1'b1;
        vtx_wr_sel = sel;
        vtx_wr_x   = COORD_W'(x);
        vtx_wr_y   = COORD_W'(y);
        tick();
        vtx_wr_en  = 1'b0;
    endtask

    task automatic commit();
        tri_commit = 1'b1;
        tick();
        tri_commit = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int k = 0; k < 10 && cfg_busy; k++) tick();
        chk("cfg_busy_clear", 64'(cfg_busy), 64'(0));
    endtask

    task automatic send_pix(input int x, input int y);
        bit ok;
        ok        = 1'b0;
        pix_x     = COORD_W'(x);
        pix_y     = COORD_W'(y);
        pix_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("accept(%0d,%0d)", x, y), 64'(ok), 64'(1));
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 60 && res_edge.size() < n; k++) tick();
        repeat (10) tick();
        chk("result_count", 64'(res_edge.size()), 64'(n));
    endtask

    task automatic chk_res(input int i, input logic [2:0] m, input logic h);
        chk($sformatf("result_present[%0d]", i), 64'(res_edge.size() > i && acc_edge.size() > i), 64'(1));
        if (res_edge.size() > i && acc_edge.size() > i) begin
            chk($sformatf("out_mask[%0d]", i), 64'(res_mask[i]), 64'(m));
            chk($sformatf("out_hit[%0d]", i), 64'(res_hit[i]), 64'(h));
            chk($sformatf("latency[%0d]", i), 64'(res_edge[i] - acc_edge[i]), 64'(7));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, held in reset and after release.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_cfg_busy", 64'(cfg_busy), 64'(0));
        chk("rst_tri_valid", 64'(tri_valid), 64'(0));
        rst = 1'b0;
        tick();
        chk("rel_pix_ready", 64'(pix_ready), 64'(1));
        chk("rel_out_mask", 64'(out_mask), 64'(0));
        chk("rel_out_hit", 64'(out_hit), 64'(0));

        // Pixel before any commit: result produced, mask forced to zero.
        clear_q();
        send_pix(50, 0);
        wait_res(1);
        chk_res(0, 3'b000, 1'b0);
        chk("pre_commit_tri_valid", 64'(tri_valid), 64'(0));

        // Load A(0,0) B(100,0) C(0,100).
        wr_vtx(2'd0, 0, 0);
        wr_vtx(2'd1, 100, 0);
        wr_vtx(2'd2, 0, 100);
        commit();
        chk("commit_busy", 64'(cfg_busy), 64'(1));
        fstart();
        wait_not_busy();
        chk("load_tri_valid", 64'(tri_valid), 64'(1));

        clear_q();
        send_pix(50, 0);
        wait_res(1);
        chk_res(0, 3'b001, 1'b1);

        // Back-to-back stream.
        clear_q();
        send_pix(50, 50);
        send_pix(0, 0);
        send_pix(30, 30);
        send_pix(101, 0);
        wait_res(4);
        chk_res(0, 3'b010, 1'b1);
        chk_res(1, 3'b101, 1'b1);
        chk_res(2, 3'b000, 1'b0);
        chk_res(3, 3'b000, 1'b0);
        for (int i = 1; i < 4; i++)
            if (res_edge.size() > i)
                chk($sformatf("spacing[%0d]", i), 64'(res_edge[i] - res_edge[i-1]), 64'(3));

        // New triangle A(10,10) B(60,10) C(10,60); write while busy must be dropped.
        clear_q();
        wr_vtx(2'd0, 10, 10);
        wr_vtx(2'd1, 60, 10);
        wr_vtx(2'd2, 10, 60);
        commit();
        chk("commit2_busy", 64'(cfg_busy), 64'(1));
        wr_vtx(2'd0, 35, 10);
        send_pix(50, 0);
        pix_x     = COORD_W'(35);
        pix_y     = COORD_W'(10);
        pix_valid = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("armed_edge2_ready", 64'(pix_ready), 64'(0));
        chk("armed_edge2_busy", 64'(cfg_busy), 64'(1));
        tick();
        chk("armed_idle_ready", 64'(pix_ready), 64'(0));
        tick();
        chk("swapped_busy", 64'(cfg_busy), 64'(0));
        chk("swapped_ready", 64'(pix_ready), 64'(1));
        chk("held_not_accepted", 64'(acc_edge.size()), 64'(1));
        send_pix(35, 10);
        wait_res(2);
        chk_res(0, 3'b001, 1'b1);
        chk_res(1, 3'b001, 1'b1);

        // Reset during EDGE1 with two pixels in flight.
        clear_q();
        send_pix(50, 0);
        send_pix(50, 50);
        tick();
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_tri_valid", 64'(tri_valid), 64'(0));
        chk("midrst_cfg_busy", 64'(cfg_busy), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("postrst_no_results", 64'(res_edge.size()), 64'(0));
        chk("postrst_pix_ready", 64'(pix_ready), 64'(1));
        chk("postrst_out_mask", 64'(out_mask), 64'(0));
        chk("postrst_out_hit", 64'(out_hit), 64'(0));

        // Degenerate triangle A=B=C=(5,5).
        wr_vtx(2'd0, 5, 5);
        wr_vtx(2'd1, 5, 5);
        wr_vtx(2'd2, 5, 5);
        commit();
        fstart();
        wait_not_busy();
        clear_q();
        send_pix(5, 5);
        send_pix(6, 5);
        wait_res(2);
        chk_res(0, 3'b111, 1'b1);
        chk_res(1, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
